// File: rtl/scale_sequencer.sv
// scale_sequencer: clears the frame buffer, launches one of four scaling engines and muxes its writes to the RAM
module scale_sequencer #(
    parameter int RAM_DEPTH = 76800,
    parameter int TIMEOUT   = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        clr_en,
    input  logic        abort,
    output logic [3:0]  eng_start,
    input  logic [3:0]  eng_done,
    input  logic [75:0] eng_wraddr,
    input  logic [31:0] eng_wrdata,
    input  logic [3:0]  eng_wren,
    output logic [18:0] ram_wraddr,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  active_mode
);
    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, FINISH} state_t;
    state_t      state_q, state_d;
    logic [18:0] clr_cnt_q, clr_cnt_d;
    logic [31:0] wd_q, wd_d;
    logic [1:0]  mode_q, mode_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [3:0]  eng_start_q, eng_start_d;
    logic [6:0]  addr_lo;
    logic [4:0]  data_lo;

    // next state, counters and the registered status outputs they imply
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wd_d      = wd_q;
        mode_d    = mode_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                mode_d    = mode;
                err_d     = 1'b0;
                clr_cnt_d = '0;
                state_d   = clr_en ? CLEAR : LAUNCH;
            end
            CLEAR: if (abort) state_d = IDLE;
                   else if (clr_cnt_q == 19'(RAM_DEPTH - 1)) state_d = LAUNCH;
                   else clr_cnt_d = clr_cnt_q + 19'd1;
            LAUNCH: begin
                state_d = abort ? IDLE : RUN;
                wd_d    = '0;
            end
            // done is ignored while wd_q is 0: the engine may still show its previous done
            RUN: if (abort) state_d = IDLE;
                 else if (wd_q != 32'd0 && eng_done[mode_q]) state_d = FINISH;
                 else if (wd_q == 32'(TIMEOUT - 1)) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                 end
                 else wd_d = wd_q + 32'd1;
            default: state_d = IDLE;
        endcase
        busy_d      = state_d != IDLE;
        done_d      = state_d == FINISH;
        eng_start_d = (state_d == LAUNCH) ? (4'b0001 << mode_d) : 4'b0000;
    end

    // all state, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            wd_q        <= '0;
            mode_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            eng_start_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wd_q        <= wd_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
        end
    end

    // RAM port: zero fill in CLEAR, combinational pass-through of the selected engine in RUN
    always_comb begin
        addr_lo    = 7'(mode_q) * 7'd19;
        data_lo    = {mode_q, 3'b000};
        ram_wren   = (state_q == CLEAR) || (state_q == RUN && eng_wren[mode_q]);
        ram_wraddr = (state_q == CLEAR) ? clr_cnt_q :
                     (state_q == RUN)   ? eng_wraddr[addr_lo +: 19] : '0;
        ram_data   = (state_q == RUN)   ? eng_wrdata[data_lo +: 8] : '0;
    end

    assign eng_start   = eng_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign active_mode = mode_q;
endmodule
